// File: rtl/chunked_serial_adder_if.sv
// Operand/result bundle for chunked_serial_adder: the requester drives start and operands,
// and the adder returns its registered result together with busy/done.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, cin, sub,
    input  sum, cout, ovf, busy, done
  );

  modport slave (
    input  start, a, b, cin, sub,
    output sum, cout, ovf, busy, done
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: captures operands, adds CHUNK bits per clock with a
// running carry, and publishes sum/cout/ovf together with a one-cycle done pulse.
module chunked_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  chunked_serial_adder_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = $clog2(NCH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [CW-1:0]    k;
  logic [WIDTH-1:0] psum;

  logic [CHUNK-1:0] ach;
  logic [CHUNK-1:0] bch;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] nsum;
  logic             last;

  // Current chunk slice and the partial-sum word with this chunk merged in.
  always_comb begin
    ach  = opa[int'(k) * CHUNK +: CHUNK];
    bch  = opb[int'(k) * CHUNK +: CHUNK];
    csum = {1'b0, ach} + {1'b0, bch} + {{CHUNK{1'b0}}, carry};
    nsum = psum;
    nsum[int'(k) * CHUNK +: CHUNK] = csum[CHUNK-1:0];
    last = (k == CW'(NCH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // Subtraction is folded into capture (~b, carry-in 1) so RUN only ever adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa      <= '0;
      opb      <= '0;
      carry    <= 1'b0;
      k        <= '0;
      psum     <= '0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            opa   <= bus.a;
            opb   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub | bus.cin;
            k     <= '0;
            psum  <= '0;
          end
        end
        RUN: begin
          psum  <= nsum;
          carry <= csum[CHUNK];
          k     <= k + CW'(1);
          if (last) begin
            bus.sum  <= nsum;
            bus.cout <= csum[CHUNK];
            // Carry into the MSB is recovered from the MSB operand and sum bits.
            bus.ovf  <= opa[WIDTH-1] ^ opb[WIDTH-1] ^ nsum[WIDTH-1] ^ csum[CHUNK];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder: 8/2, 16/16 and 16/4 instances checked
// against a plain-arithmetic reference of add/subtract with carry and signed overflow.
module tb_chunked_serial_adder;
  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        q8[$];
  exp_t        q16a[$];
  exp_t        q16b[$];
  logic [15:0] prev8;

  chunked_serial_adder_if #(.WIDTH(8))  bus8();
  chunked_serial_adder_if #(.WIDTH(16)) bus16a();
  chunked_serial_adder_if #(.WIDTH(16)) bus16b();

  chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );
  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut16a (
    .clk(clk), .rst_n(rst_n), .bus(bus16a)
  );
  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut16b (
    .clk(clk), .rst_n(rst_n), .bus(bus16b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [31:0] mask, bb, full;
    mask   = (32'd1 << w) - 32'd1;
    bb     = sub ? (~{16'h0, b}) & mask : {16'h0, b};
    full   = {16'h0, a} + bb + {31'h0, (sub ? 1'b1 : cin)};
    e.sum  = full[15:0] & mask[15:0];
    e.cout = full[w];
    e.ovf  = (a[w-1] == bb[w-1]) && (e.sum[w-1] != a[w-1]);
    e.due  = 0;
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e, input logic [15:0] s,
                         input logic co, input logic ov, input logic bz);
    check({tag, "_sum"}, {16'h0, s}, {16'h0, e.sum});
    check({tag, "_cout"}, {31'h0, co}, {31'h0, e.cout});
    check({tag, "_ovf"}, {31'h0, ov}, {31'h0, e.ovf});
    check({tag, "_latency"}, cyc, e.due);
    check({tag, "_busy_at_done"}, {31'h0, bz}, 32'd1);
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus8.done === 1'b1) begin
      if (q8.size() == 0) check("done8_unexpected", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        compare("r8", e, {8'h0, bus8.sum}, bus8.cout, bus8.ovf, bus8.busy);
        prev8 = e.sum;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus16a.done === 1'b1) begin
      if (q16a.size() == 0) check("done16a_unexpected", 32'd1, 32'd0);
      else begin
        e = q16a.pop_front();
        compare("r16a", e, bus16a.sum, bus16a.cout, bus16a.ovf, bus16a.busy);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus16b.done === 1'b1) begin
      if (q16b.size() == 0) check("done16b_unexpected", 32'd1, 32'd0);
      else begin
        e = q16b.pop_front();
        compare("r16b", e, bus16b.sum, bus16b.cout, bus16b.ovf, bus16b.busy);
      end
    end
  end

  task automatic wait_idle(input int sel);
    int  n;
    logic bz;
    n = 0;
    forever begin
      bz = (sel == 0) ? bus8.busy : (sel == 1) ? bus16a.busy : bus16b.busy;
      if (bz !== 1'b1 || n >= 40) break;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Drives one request; operands are scrambled after capture to prove they are latched.
  task automatic issue(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s);
    exp_t e;
    wait_idle(sel);
    if (sel == 0) begin
      bus8.start = 1'b1; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.cin = c; bus8.sub = s;
    end else if (sel == 1) begin
      bus16a.start = 1'b1; bus16a.a = a; bus16a.b = b; bus16a.cin = c; bus16a.sub = s;
    end else begin
      bus16b.start = 1'b1; bus16b.a = a; bus16b.b = b; bus16b.cin = c; bus16b.sub = s;
    end
    @(posedge clk); #1;
    if (sel == 0) begin
      e = model(8, a, b, c, s); e.due = cyc + 4;
      bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      bus8.cin = 1'($urandom); bus8.sub = 1'($urandom);
      q8.push_back(e);
    end else if (sel == 1) begin
      e = model(16, a, b, c, s); e.due = cyc + 1;
      bus16a.start = 1'b0; bus16a.a = 16'($urandom); bus16a.b = 16'($urandom);
      q16a.push_back(e);
    end else begin
      e = model(16, a, b, c, s); e.due = cyc + 4;
      bus16b.start = 1'b0; bus16b.a = 16'($urandom); bus16b.b = 16'($urandom);
      q16b.push_back(e);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   cnt;
    exp_t e;
    checks = 0; errors = 0; prev8 = 16'h0;
    rst_n = 1'b0;
    bus8.start = 0;   bus8.a = '0;   bus8.b = '0;   bus8.cin = 0;   bus8.sub = 0;
    bus16a.start = 0; bus16a.a = '0; bus16a.b = '0; bus16a.cin = 0; bus16a.sub = 0;
    bus16b.start = 0; bus16b.a = '0; bus16b.b = '0; bus16b.cin = 0; bus16b.sub = 0;
    #2;
    check("rst_sum", {24'h0, bus8.sum}, 32'h0);
    check("rst_flags", {28'h0, bus8.cout, bus8.ovf, bus8.busy, bus8.done}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed add/subtract corner vectors.
    issue(0, 16'h00, 16'h00, 1'b1, 1'b0);
    issue(0, 16'hFF, 16'hFF, 1'b0, 1'b0);
    issue(0, 16'hAA, 16'hFF, 1'b1, 1'b0);
    issue(0, 16'hBB, 16'hAE, 1'b0, 1'b0);
    issue(0, 16'hD5, 16'h9D, 1'b1, 1'b0);
    issue(0, 16'h05, 16'h03, 1'b0, 1'b1);
    issue(0, 16'h03, 16'h05, 1'b1, 1'b1);
    issue(0, 16'h80, 16'h01, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      issue(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
            1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // start held high with operands churning through RUN and DONE.
    wait_idle(0);
    bus8.start = 1'b1; bus8.a = 8'h3C; bus8.b = 8'h5A; bus8.cin = 1'b1; bus8.sub = 1'b0;
    @(posedge clk); #1;
    e = model(8, 16'h3C, 16'h5A, 1'b1, 1'b0); e.due = cyc + 4;
    q8.push_back(e);
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (bus8.busy === 1'b1) cnt++;
      if (i == 2) check("sum8_hold_during_run", {16'h0, 8'h0, bus8.sum}, {16'h0, prev8});
      if (i <= 4) begin
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.sub = 1'($urandom);
      end
      if (i == 5) bus8.start = 1'b0;
    end
    check("busy8_cycles", cnt, 32'd5);
    @(posedge clk); #1;

    // Reset in the middle of an operation (chunk 2 pending).
    issue(0, 16'h77, 16'h66, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'h0, bus8.busy}, 32'h0);
    check("midrst_sum", {24'h0, bus8.sum}, 32'h0);
    check("midrst_flags", {29'h0, bus8.cout, bus8.ovf, bus8.done}, 32'h0);
    if (q8.size() > 0) void'(q8.pop_back());
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(0, 16'h01, 16'h01, 1'b0, 1'b0);

    // Wide instances: single-chunk and four-chunk.
    issue(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    issue(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      issue(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      issue(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (10) @(posedge clk);
    #1;
    check("q8_drained", q8.size(), 32'd0);
    check("q16a_drained", q16a.size(), 32'd0);
    check("q16b_drained", q16b.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
